arbitro_bits8_carriles: RTL
===========================

# arbitro_bits8_carriles

Round-robin scheduler that shares the single 8-bit byte lane feeding the 8-to-32-bit word converter among four byte-stream requesters. It grants one requester per 4-cycle word slot, pops exactly four bytes from it (MSB first), and drives the converter's `valid_in` / `Data_in` together with word-framing and lane-ID sideband. It runs entirely in the `clk_4f` domain.

## Interface
Parameters:
- `ANCHO_DATO`, default 8: byte width. Only 8 is supported.
- `N_CARRILES`, default 4: number of requesters. Fixed at 4, so the lane ID is 2 bits.

Ports:
- `clk_4f` in 1: sole clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-low. Sampled on `clk_4f`; 0 = reset.
- `req` in 4: `req[i]=1` means requester i holds at least one full word (4 bytes) ready.
- `mascara` in 4: lane enable; `mascara[i]=0` excludes lane i from arbitration.
- `data_carril` in 32: bytes presented first-word-fall-through by each lane; lane i is at `[8*i+7:8*i]`.
- `pop` out 4: one-hot pop strobe, combinational. The byte on lane i is consumed in the same cycle `pop[i]=1`.
- `valid_out` out 1: byte on `Data_out` is valid. Feeds the converter's `valid_in`.
- `Data_out` out 8: registered byte to the converter.
- `sof_out` out 1: marks the first (MSB) byte of a word.
- `carril_out` out 2: lane ID of the byte on `Data_out`.
- `fase_out` out 2: phase (0..3) of the byte on `Data_out`.

## Operation
- **Slot counter.** A free-running 2-bit counter `fase` runs 0→1→2→3→0, one slot every 4 cycles, and wraps with no gap.
- **Arbitration** happens only when `fase==0`, over `elegibles = req & mascara`.
  - The search starts at `(ultimo+1) mod 4` and goes upward with wrap; the first set bit wins.
  - If a lane wins: `activo<=1`, `grant<=winner`, `ultimo<=winner`.
  - If no lane is eligible: `activo<=0` for the whole slot, and `ultimo` is unchanged.
- **Transfer.** While the slot is active, `pop[grant]=1` on phases 0,1,2,3.
  - At phase 0, `pop` is driven from the combinational winner.
  - At phases 1–3, `pop` is driven from the registered `grant`.
  - Exactly 4 pops per granted slot; never a pop on a non-granted lane.
- **Mid-slot changes are ignored.** Once granted, the slot completes even if `req[grant]` or `mascara[grant]` drops. Requesters guarantee 4 bytes whenever `req` is high. New `req`/`mascara` values are seen only at the next phase 0.
- **Output stage** (registered, one cycle after pop):
  - `Data_out <= data_carril[grant]`, `valid_out <= pop` was active.
  - `sof_out <= (fase==0 && pop active)`.
  - `carril_out <= lane`, `fase_out <= fase`.
  - In idle slots: `valid_out=0`, `sof_out=0`, `Data_out=8'h00`; `carril_out` and `fase_out` keep tracking (`carril_out=0` in idle slots).
- **Reset values:** `fase=0`, `ultimo=3` (so lane 0 is first priority), `activo=0`, `grant=0`, `valid_out=0`, `Data_out=0`, `sof_out=0`, `carril_out=0`, `fase_out=0`.
- **Pop during reset:** `pop` is forced to 4'b0 whenever `reset==0`, even though it is combinational.
- **Reset mid-slot:** the slot is abandoned and bytes already popped are lost. The first cycle after release is phase 0 of a fresh slot. Requesters are reset by the same signal.

## Timing
- Pop-to-output latency: 1 cycle. A byte popped in cycle t appears on `Data_out` with `valid_out=1` in cycle t+1.
- A granted slot yields 4 consecutive valid bytes on `Data_out`, MSB first, with `sof_out` on the first byte.
- Back-to-back granted slots produce a continuous stream: `valid_out` stays high with no bubble.
- First possible `sof_out` is 1 cycle after reset release, provided some lane is eligible at phase 0.
- Fairness: with all 4 lanes continuously eligible, grant order is 0,1,2,3,0,…; each lane gets 1 slot per 16 cycles.
- Simultaneous events at phase 0:
  - If `req` rises on the same cycle it is sampled, it is considered.
  - If the lane just served is the only eligible lane, it is granted again immediately.

## Structure
- Shared package `arbitro_pkg`:
  - constants `N_CARRILES=4`, `BYTES_POR_PALABRA=4`, `ANCHO_DATO=8`;
  - typedef `id_carril_t` (2 bits);
  - typedef `fase_t` (2 bits).
- Sub-module `arbitro_rr_prioridad`: combinational round-robin priority encoder.
  - Inputs: 4-bit `elegibles`, 2-bit `ultimo`.
  - Outputs: `hay_ganador`, 2-bit `ganador`.
- The top level holds the phase counter, the grant/pointer registers and the output register stage.

## Test plan
- **Single requester:** lane 2 only `req=1` with bytes AA,BB,CC,DD, `mascara=4'hF` → `pop[2]` for 4 cycles; `Data_out` = AA,BB,CC,DD with `valid_out=1`, `sof_out` only on AA, `carril_out=2`, `fase_out` = 0,1,2,3.
- **All lanes requesting:** `req=4'hF` continuously after reset → grant order 0,1,2,3,0 with 20 consecutive valid bytes, no bubbles.
- **Masking and idle slots:** `req=4'hF`, `mascara=4'b1010` → lanes 1,3,1,3 alternate. Then `mascara=0` → idle slots with `pop=0`, `valid_out=0`, `Data_out=00`.
- **Request drop mid-slot:** lane 0 `req` drops at phase 1 → all 4 pops and 4 valid bytes still occur; lane 0 is not granted at the next phase 0.
- **Reset mid-slot:** `reset=0` at phase 2 of a lane-1 slot → `pop=0` in that same cycle. After release, all outputs are 0, `fase` restarts at 0, and lane 0 has first priority.
- **Mask change mid-slot:** `mascara` changes at phase 2 → takes effect only at the next phase 0; the current slot completes unchanged.

Source files
------------

// File: rtl/arbitro_pkg.sv
// Shared types and constants for the four-lane byte arbiter feeding the 8-to-32 converter.
package arbitro_pkg;

  localparam int unsigned N_CARRILES        = 4;
  localparam int unsigned BYTES_POR_PALABRA = 4;
  localparam int unsigned ANCHO_DATO        = 8;

  typedef logic [1:0] id_carril_t;
  typedef logic [1:0] fase_t;

endpackage

// File: rtl/arbitro_rr_prioridad.sv
// Combinational round-robin priority encoder: the search starts just above the last winner.
module arbitro_rr_prioridad
  import arbitro_pkg::*;
(
  input  logic [N_CARRILES-1:0] elegibles,
  input  id_carril_t            ultimo,
  output logic                  hay_ganador,
  output id_carril_t            ganador
);

  id_carril_t cand;

  // Walk from farthest to nearest so the nearest eligible lane after ultimo wins last.
  always_comb begin
    hay_ganador = 1'b0;
    ganador     = '0;
    cand        = '0;
    for (int k = N_CARRILES; k >= 1; k--) begin
      cand = id_carril_t'(int'(ultimo) + k);
      if (elegibles[cand]) begin
        hay_ganador = 1'b1;
        ganador     = cand;
      end
    end
  end

endmodule

// File: rtl/arbitro_bits8_carriles.sv
// Round-robin scheduler sharing one byte lane among four requesters, one 4-byte word per slot.
module arbitro_bits8_carriles #(
  parameter int unsigned ANCHO_DATO = 8,
  parameter int unsigned N_CARRILES = 4
) (
  input  logic                             clk_4f,
  input  logic                             reset,
  input  logic [N_CARRILES-1:0]            req,
  input  logic [N_CARRILES-1:0]            mascara,
  input  logic [N_CARRILES*ANCHO_DATO-1:0] data_carril,
  output logic [N_CARRILES-1:0]            pop,
  output logic                             valid_out,
  output logic [ANCHO_DATO-1:0]            Data_out,
  output logic                             sof_out,
  output logic [1:0]                       carril_out,
  output logic [1:0]                       fase_out
);

  import arbitro_pkg::id_carril_t;
  import arbitro_pkg::fase_t;
  import arbitro_pkg::BYTES_POR_PALABRA;

  localparam fase_t FASE_ULTIMA = fase_t'(BYTES_POR_PALABRA - 1);

  fase_t                   fase;
  id_carril_t              ultimo;
  id_carril_t              grant;
  logic                    activo;
  logic [N_CARRILES-1:0]   elegibles;
  logic                    hay_ganador;
  id_carril_t              ganador;
  logic                    ocupado;
  id_carril_t              carril;
  logic [ANCHO_DATO-1:0]   byte_sel;

  assign elegibles = req & mascara;

  arbitro_rr_prioridad u_rr (
    .elegibles   (elegibles),
    .ultimo      (ultimo),
    .hay_ganador (hay_ganador),
    .ganador     (ganador)
  );

  // Phase 0 serves the fresh winner directly; later phases replay the registered grant.
  always_comb begin
    ocupado = 1'b0;
    carril  = '0;
    if (fase == '0) begin
      ocupado = hay_ganador;
      carril  = hay_ganador ? ganador : id_carril_t'(0);
    end else begin
      ocupado = activo;
      carril  = activo ? grant : id_carril_t'(0);
    end
  end

  assign pop      = (reset && ocupado) ? (N_CARRILES'(1) << carril) : '0;
  assign byte_sel = data_carril[ANCHO_DATO*int'(carril) +: ANCHO_DATO];

  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      fase       <= '0;
      ultimo     <= id_carril_t'(N_CARRILES - 1);
      grant      <= '0;
      activo     <= 1'b0;
      valid_out  <= 1'b0;
      Data_out   <= '0;
      sof_out    <= 1'b0;
      carril_out <= '0;
      fase_out   <= '0;
    end else begin
      fase <= (fase == FASE_ULTIMA) ? fase_t'(0) : fase + fase_t'(1);
      if (fase == '0) begin
        activo <= hay_ganador;
        if (hay_ganador) begin
          grant  <= ganador;
          ultimo <= ganador;
        end
      end
      valid_out  <= ocupado;
      Data_out   <= ocupado ? byte_sel : '0;
      sof_out    <= ocupado && (fase == '0);
      carril_out <= carril;
      fase_out   <= fase;
    end
  end

endmodule
